// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI transmit path.
// Holds the standard MIDI bit rate, status-byte range constants, the
// transmit FSM state type and helpers that classify a byte for the
// running-status logic.
package midi_pkg;

   localparam int         MIDI_BAUD     = 31250;
   localparam logic [7:0] ST_MASK       = 8'h80;
   localparam logic [7:0] SYS_COMMON_LO = 8'hF0;
   localparam logic [7:0] RT_LO         = 8'hF8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Channel voice status: 0x80-0xEF.
   function automatic logic is_channel_status(input logic [7:0] b);
      return ((b & ST_MASK) != 8'h00) && (b < SYS_COMMON_LO);
   endfunction

   // System common: 0xF0-0xF7. These cancel any held running status.
   function automatic logic is_sys_common(input logic [7:0] b);
      return (b >= SYS_COMMON_LO) && (b < RT_LO);
   endfunction

endpackage

// File: rtl/midi_uart_tx_if.sv
// Handshake and status bundle of the MIDI transmitter.
//   in_data/in_valid/in_ready : FIFO byte stream from the MIDI-out formatter
//   rt_data/rt_valid/rt_ready : real-time byte request (bypasses the FIFO)
//   midi_txd                  : serial line, idle high
//   busy, fifo_level          : status
// master = byte source side, slave = transmitter.
interface midi_uart_tx_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       rt_data;
   logic             rt_valid;
   logic             rt_ready;
   logic             midi_txd;
   logic             busy;
   logic [LVL_W-1:0] fifo_level;

   modport master (
      output in_data, in_valid, rt_data, rt_valid,
      input  in_ready, rt_ready, midi_txd, busy, fifo_level
   );

   modport slave (
      input  in_data, in_valid, rt_data, rt_valid,
      output in_ready, rt_ready, midi_txd, busy, fifo_level
   );
endinterface

// File: rtl/midi_tx_fifo.sv
// Synchronous byte FIFO for the MIDI transmitter.
//   i_clk, i_rst : clock, synchronous active-high reset
//   push, wdata  : write request and data (ignored when full unless popping)
//   pop, rdata   : read request; rdata shows the head entry combinationally
//   full, empty, level : occupancy flags and count
// DEPTH must be a power of 2 so the pointers wrap for free.
module midi_tx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);
   import midi_pkg::*;

   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic          w_do_push;
   logic          w_do_pop;

   assign full  = (r_level == LVL_FULL);
   assign empty = (r_level == '0);
   assign level = r_level;
   assign rdata = r_mem[r_rptr];

   // A pop frees the slot the push needs, so both proceed even when full.
   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr] <= wdata;
   end

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI serial transmitter: 8N1, LSB first, idle high.
//   CLOCK_25 : system clock
//   iRST     : synchronous reset, active-high
//   bus      : midi_uart_tx_if slave (FIFO stream, real-time request,
//              serial line, busy, fifo_level)
// Real-time bytes wait in a one-entry holding register and win every
// frame-boundary selection over the FIFO. Repeated channel status bytes
// popped from the FIFO are dropped when RUNNING_STATUS is set.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | line high, selecting the next byte each cycle
// ST_START | start bit (0) for BIT_DIV cycles
// ST_DATA  | data bits 0..7, BIT_DIV cycles each
// ST_STOP  | stop bit (1); selects the next byte on its last cycle
module midi_uart_tx
   import midi_pkg::*;
#(
   parameter int CLK_HZ         = 25000000,
   parameter int BAUD           = MIDI_BAUD,
   parameter int FIFO_DEPTH     = 16,
   parameter int RUNNING_STATUS = 1
) (
   input  logic          CLOCK_25,
   input  logic          iRST,
   midi_uart_tx_if.slave bus
);
   localparam int BIT_DIV = CLK_HZ / BAUD;
   localparam int CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int LW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BIT_DIV - 1);

   tx_state_t        r_state;
   tx_state_t        w_state_nxt;
   logic [CNT_W-1:0] r_baud_cnt;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shift;
   logic             r_txd;
   logic             w_txd_nxt;
   logic             r_stop_tail;
   logic [7:0]       r_rs;
   logic             r_rs_valid;
   logic [7:0]       r_rt_data;
   logic             r_rt_full;

   logic             w_tick;
   logic             w_sel;
   logic             w_take_rt;
   logic             w_pop;
   logic             w_discard;
   logic             w_load;
   logic [7:0]       w_load_byte;
   logic [7:0]       w_rdata;
   logic             w_full;
   logic             w_empty;
   logic [LW-1:0]    w_level;

   midi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk (CLOCK_25),
      .i_rst (iRST),
      .push  (bus.in_valid && !w_full),
      .pop   (w_pop),
      .wdata (bus.in_data),
      .rdata (w_rdata),
      .full  (w_full),
      .empty (w_empty),
      .level (w_level)
   );

   assign w_tick = (r_baud_cnt == '0);

   // Selection points: any idle cycle, or the last cycle of a stop bit so
   // the next start bit follows with no gap.
   assign w_sel       = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_tick);
   assign w_take_rt   = w_sel && r_rt_full;
   assign w_pop       = w_sel && !r_rt_full && !w_empty;
   assign w_discard   = w_pop && (RUNNING_STATUS != 0) && r_rs_valid &&
                        is_channel_status(w_rdata) && (w_rdata == r_rs);
   assign w_load      = w_take_rt || (w_pop && !w_discard);
   assign w_load_byte = w_take_rt ? r_rt_data : w_rdata;

   assign bus.in_ready   = !w_full;
   assign bus.rt_ready   = !r_rt_full;
   assign bus.midi_txd   = r_txd;
   assign bus.fifo_level = w_level;
   // r_stop_tail covers the final cycle the stop bit is on the wire, since
   // r_txd lags the state by one clock.
   assign bus.busy       = (r_state != ST_IDLE) || !w_empty || r_rt_full || r_stop_tail;

   always_ff @(posedge CLOCK_25) begin
      if (iRST) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_load) w_state_nxt = ST_START;
         ST_START: if (w_tick) w_state_nxt = ST_DATA;
         ST_DATA:  if (w_tick && (r_bit_cnt == 3'd7)) w_state_nxt = ST_STOP;
         ST_STOP:  if (w_tick) w_state_nxt = w_load ? ST_START : ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_txd_nxt = 1'b1;
      case (r_state)
         ST_START: w_txd_nxt = 1'b0;
         ST_DATA:  w_txd_nxt = r_shift[0];
         default:  w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge CLOCK_25) begin
      if (iRST) begin
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_txd       <= 1'b1;
         r_stop_tail <= 1'b0;
         r_rs        <= '0;
         r_rs_valid  <= 1'b0;
      end else begin
         r_txd       <= w_txd_nxt;
         r_stop_tail <= (r_state == ST_STOP) && w_tick;

         if (w_load) begin
            r_shift    <= w_load_byte;
            r_baud_cnt <= CNT_RELOAD;
         end else if (r_state == ST_IDLE) begin
            r_baud_cnt <= '0;
         end else if (w_tick) begin
            r_baud_cnt <= CNT_RELOAD;
            if (r_state == ST_START) r_bit_cnt <= '0;
            if (r_state == ST_DATA) begin
               r_shift   <= {1'b0, r_shift[7:1]};
               r_bit_cnt <= r_bit_cnt + 3'd1;
            end
         end else begin
            r_baud_cnt <= r_baud_cnt - CNT_W'(1);
         end

         // Only FIFO bytes touch the held status; real-time bytes never do.
         if ((RUNNING_STATUS != 0) && w_pop && !w_discard) begin
            if (is_channel_status(w_rdata)) begin
               r_rs       <= w_rdata;
               r_rs_valid <= 1'b1;
            end else if (is_sys_common(w_rdata)) begin
               r_rs_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_25) begin
      if (iRST) begin
         r_rt_full <= 1'b0;
         r_rt_data <= '0;
      end else begin
         if (w_take_rt) r_rt_full <= 1'b0;
         if (bus.rt_valid && !r_rt_full) begin
            r_rt_full <= 1'b1;
            r_rt_data <= bus.rt_data;
         end
      end
   end

endmodule
